// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// datapath mux selects and fault codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC      = 4'd6,
        ST_R_WB      = 4'd7,
        ST_ADDI_WB   = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_FAULT     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait watchdog. Counts cycles spent waiting on mem_ready; expired
// fires on the wait cycle that brings the count to TIMEOUT, so the FSM leaves
// for FAULT after exactly TIMEOUT wait cycles. A ready cycle never expires.
module mc_mem_wait #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = clk ^ reset ^ clear ^ waiting;
            assign expired   = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            logic [CW-1:0] count;

            // Wait-cycle counter, restarted whenever the FSM changes state.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (waiting) begin
                    count <= count + CW'(1);
                end
            end

            assign expired = waiting && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: sequences fetch/decode/execute/memory/
// writeback, drives per-state datapath strobes, and parks in a sticky FAULT
// state on illegal opcodes or a memory timeout. All outputs are forced low
// while reset is asserted.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter bit ENABLE_J    = 1'b1,
    parameter bit ENABLE_ADDI = 1'b1,
    parameter int TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrc_a,
    output logic [1:0] alusrc_b,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [3:0] state,
    output logic       fault,
    output logic [1:0] fault_code
);

    state_t     state_q, state_d;
    logic       fault_q;
    logic [1:0] fault_code_q, fault_code_d;
    logic       expired;

    logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c;
    logic       pc_write_cond_c, regwrite_c, regdst_c, memtoreg_c, alusrc_a_c;
    logic [1:0] alusrc_b_c, aluop_c, pcsrc_c;

    logic is_lw, is_sw, is_r, is_beq, is_j, is_addi;
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_r    = (opcode == OP_RTYPE);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_j    = (opcode == OP_J) && ENABLE_J;
    assign is_addi = (opcode == OP_ADDI) && ENABLE_ADDI;

    mc_mem_wait #(.TIMEOUT(TIMEOUT)) u_mem_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_d != state_q),
        .waiting (mem_req_c && !mem_ready),
        .expired (expired)
    );

    // State and sticky fault registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_FETCH;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            fault_q      <= fault_q || (state_d == ST_FAULT);
            fault_code_q <= fault_code_d;
        end
    end

    // Next-state selection and fault cause capture.
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        case (state_q)
            ST_FETCH, ST_MEM_READ, ST_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = (state_q == ST_FETCH)    ? ST_DECODE :
                              (state_q == ST_MEM_READ) ? ST_MEM_WB : ST_FETCH;
                end else if (expired) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (is_lw || is_sw || is_addi) state_d = ST_MEM_ADDR;
                else if (is_r)                 state_d = ST_EXEC;
                else if (is_beq)               state_d = ST_BRANCH;
                else if (is_j)                 state_d = ST_JUMP;
                else begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_ILLEGAL;
                end
            end
            ST_MEM_ADDR: begin
                if (is_lw)        state_d = ST_MEM_READ;
                else if (is_sw)   state_d = ST_MEM_WRITE;
                else if (is_addi) state_d = ST_ADDI_WB;
                else begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_ILLEGAL;
                end
            end
            ST_EXEC:                                  state_d = ST_R_WB;
            ST_MEM_WB, ST_R_WB, ST_ADDI_WB,
            ST_BRANCH, ST_JUMP:                       state_d = ST_FETCH;
            ST_FAULT:                                 state_d = ST_FAULT;
            default:                                  state_d = ST_FAULT;
        endcase
    end

    // Per-state datapath strobes; only FETCH looks at mem_ready.
    always_comb begin
        mem_req_c       = 1'b0;
        mem_we_c        = 1'b0;
        iord_c          = 1'b0;
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        regwrite_c      = 1'b0;
        regdst_c        = 1'b0;
        memtoreg_c      = 1'b0;
        alusrc_a_c      = 1'b0;
        alusrc_b_c      = SRCB_RT;
        aluop_c         = ALU_ADD;
        pcsrc_c         = PCSRC_ALU;
        case (state_q)
            ST_FETCH: begin
                mem_req_c  = 1'b1;
                alusrc_b_c = SRCB_FOUR;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
            end
            ST_DECODE:   alusrc_b_c = SRCB_IMM_SH;
            ST_MEM_ADDR: begin
                alusrc_a_c = 1'b1;
                alusrc_b_c = SRCB_IMM;
            end
            ST_MEM_READ: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
            end
            ST_MEM_WB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
            end
            ST_EXEC: begin
                alusrc_a_c = 1'b1;
                aluop_c    = ALU_FUNCT;
            end
            ST_R_WB: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
            end
            ST_ADDI_WB:  regwrite_c = 1'b1;
            ST_BRANCH: begin
                alusrc_a_c      = 1'b1;
                aluop_c         = ALU_SUB;
                pc_write_cond_c = 1'b1;
                pcsrc_c         = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write_c = 1'b1;
                pcsrc_c    = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign mem_req       = reset && mem_req_c;
    assign mem_we        = reset && mem_we_c;
    assign iord          = reset && iord_c;
    assign ir_write      = reset && ir_write_c;
    assign pc_write      = reset && pc_write_c;
    assign pc_write_cond = reset && pc_write_cond_c;
    assign regwrite      = reset && regwrite_c;
    assign regdst        = reset && regdst_c;
    assign memtoreg      = reset && memtoreg_c;
    assign alusrc_a      = reset && alusrc_a_c;
    assign alusrc_b      = reset ? alusrc_b_c : 2'b00;
    assign aluop         = reset ? aluop_c : 2'b00;
    assign pcsrc         = reset ? pcsrc_c : 2'b00;
    assign state         = reset ? state_q : ST_FETCH;
    assign fault         = reset && fault_q;
    assign fault_code    = reset ? fault_code_q : FC_NONE;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle main control decoder for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives per-state datapath strobes. A valid/ready memory handshake tolerates variable-latency memory, with a wait-cycle watchdog. Illegal opcodes and stalled memory enter a sticky FAULT state. It sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

## Interface
- ENABLE_J, 1: decode `j` (000010); when 0 it is illegal.
- ENABLE_ADDI, 1: decode `addi` (001000); when 0 it is illegal.
- TIMEOUT, 16: maximum mem_ready wait cycles before FAULT; 0 disables the watchdog.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- opcode  in  6  IR[31:26], stable from DECODE onward.
- mem_ready  in  1  memory completes the current request in this cycle.
- mem_req, mem_we, iord  out  1  memory request, write enable, address select (0 = PC, 1 = ALUOut).
- ir_write, pc_write, pc_write_cond  out  1  IR load, unconditional PC load, PC load if ALU zero.
- regwrite, regdst, memtoreg, alusrc_a  out  1  register-file and mux controls.
- alusrc_b, aluop, pcsrc  out  2  ALU B select (00 rt, 01 const 4, 10 imm, 11 imm<<2); aluop (00 add, 01 sub, 10 funct); PC source (00 ALU, 01 ALUOut, 10 jump target).
- state  out  4  current state, for debug.
- fault  out  1  sticky fault flag.
- fault_code  out  2  01 illegal opcode, 10 memory timeout, 00 none.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC, R_WB, ADDI_WB, BRANCH, JUMP, FAULT.
- Moore outputs decode from state only, except ir_write and pc_write in FETCH, which are qualified by mem_ready.
- All outputs not listed for a state are 0.
- FETCH: mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, aluop=00, pcsrc=00. On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
- DECODE: alusrc_b=11, aluop=00 (branch target into ALUOut). Next state by opcode:
  - lw (100011) or sw (101011) → MEM_ADDR.
  - R-type (000000) → EXEC.
  - beq (000100) → BRANCH.
  - j → JUMP.
  - addi → MEM_ADDR.
  - anything else → FAULT, fault_code=01.
- MEM_ADDR: alusrc_a=1, alusrc_b=10, aluop=00. Next: lw → MEM_READ, sw → MEM_WRITE, addi → ADDI_WB.
- MEM_READ: mem_req=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: regwrite=1, memtoreg=1, regdst=0. Then FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, iord=1. Wait for mem_ready, then go to FETCH. sw keeps regwrite=0.
- EXEC: alusrc_a=1, alusrc_b=00, aluop=10. Then R_WB.
- R_WB: regwrite=1, regdst=1, memtoreg=0. Then FETCH.
- ADDI_WB: regwrite=1, regdst=0, memtoreg=0. Then FETCH.
- BRANCH: alusrc_a=1, alusrc_b=00, aluop=01, pc_write_cond=1, pcsrc=01. Then FETCH.
- JUMP: pc_write=1, pcsrc=10. Then FETCH.
- FAULT: all strobes 0, fault=1. Leave only via reset.
- Watchdog:
  - Counter clears on entry to any mem_req state and increments on each cycle with mem_req=1 and mem_ready=0.
  - When the counter reaches TIMEOUT, go to FAULT with fault_code=10.
  - If mem_ready arrives in the same cycle the counter reaches TIMEOUT, mem_ready wins.
- Reset:
  - While reset==0, every output is forced to 0 combinationally, including state=FETCH encoding 0. This gating is independent of the clock.
  - At the clock edge with reset==0: state←FETCH, counter←0, fault←0, fault_code←00.
  - Reset mid-operation abandons the instruction. No memory write may be issued during reset.

## Timing
- Cycle counts, with mem_ready=1 on the first request cycle:
  - lw: 5 (FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB).
  - sw: 4.
  - R-type: 4.
  - addi: 4.
  - beq: 3.
  - j: 3.
- Each memory wait cycle adds exactly 1 cycle.
- The first mem_req appears in the first cycle after reset returns high.
- State and counter update on the rising edge. Outputs are valid combinationally within that cycle.

## Structure
- Shared package `mc_ctrl_pkg`:
  - state enum (4-bit, FETCH=0);
  - opcode constants;
  - aluop, alusrc_b and pcsrc encodings;
  - fault_code values.
- Sub-module `mc_mem_wait`: watchdog counter of width $clog2(TIMEOUT+1), with inputs clear, waiting and reset, and output expired. It is tied off when TIMEOUT=0.
- The top level holds the next-state logic, the output decode and the fault registers.

## Test plan
- Reset low for 3 cycles with mem_ready=1 → all outputs 0 and state=0. In the first cycle after release, mem_req=1 and iord=0.
- R-type, mem_ready tied 1 → 4-cycle loop. regwrite=1 and regdst=1 only in R_WB. pc_write pulses once per instruction, in FETCH.
- lw with mem_ready delayed 3 cycles on both fetch and read → 11 cycles. ir_write is high only in the fetch ready cycle. memtoreg=1 with regwrite=1 in MEM_WB.
- beq → BRANCH shows aluop=01, pcsrc=01, pc_write_cond=1. regwrite and mem_we stay 0 throughout.
- TIMEOUT=4, mem_ready held 0 in FETCH → FAULT after 4 wait cycles, with fault=1, fault_code=10 and mem_req=0. A reset pulse returns to FETCH with fault=0.
- opcode 000010 with ENABLE_J=0 → FAULT with fault_code=01. With ENABLE_J=1 → JUMP shows pc_write=1 and pcsrc=10, then FETCH.
